// File: rtl/lenet_pkg.sv
// Shared constants and scan-FSM encoding for the LeNet convolution front end.
package lenet_pkg;

  localparam int CONV_K    = 5;
  localparam int IMG_W_DEF = 32;
  localparam int IMG_H_DEF = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2
  } scan_state_e;

endpackage

// File: rtl/conv_scan_cnt.sv
// Row/column raster counter.
// The column wraps at COLS-1 and bumps the row.
// last_o flags the final position of the raster.
module conv_scan_cnt #(
  parameter int COLS = 32,
  parameter int ROWS = 28,
  parameter int CW   = 6
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clr_i,
  input  logic          en_i,
  output logic [CW-1:0] row_o,
  output logic [CW-1:0] col_o,
  output logic          last_o
);

  logic [CW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic          col_wrap;

  assign col_wrap = (col_q == CW'(COLS - 1));
  assign last_o   = col_wrap && (row_q == CW'(ROWS - 1));
  assign row_o    = row_q;
  assign col_o    = col_q;

  // Next position: clear wins over advance.
  // The last position wraps back to the origin.
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clr_i) begin
      row_d = '0;
      col_d = '0;
    end else if (en_i) begin
      if (col_wrap) begin
        col_d = '0;
        row_d = last_o ? '0 : row_q + CW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  // Position registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

endmodule

// File: rtl/conv_scan_ctrl.sv
// Raster scan controller for a KxK convolution window fed from a K-bank row buffer.
// Reads one column per cycle. A registered copy of each read coordinate follows
// the data into the window datapath; it produces the output-pixel coordinates.
// A stalled output freezes the whole pipe.
module conv_scan_ctrl import lenet_pkg::*; #(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF,
  parameter int K     = CONV_K,
  parameter int CW    = 6
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          rd_en_o,
  output logic [CW-1:0] rd_row_o,
  output logic [CW-1:0] rd_col_o,
  output logic          conv_en_o,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [CW-1:0] out_row_o,
  output logic [CW-1:0] out_col_o
);

  if (IMG_W < K || IMG_H < K) begin : g_bad_size
    $error("conv_scan_ctrl: image dimensions must be at least K");
  end
  if ((2 ** CW) < IMG_W || (2 ** CW) < IMG_H) begin : g_bad_cw
    $error("conv_scan_ctrl: CW too narrow for image coordinates");
  end

  scan_state_e   state_q, state_d;
  logic          stall, pipe_empty, cnt_clr, cnt_last;
  logic          v1_q, v1_d;
  logic [CW-1:0] r1_q, r1_d, c1_q, c1_d;
  logic          ov_q, ov_d;
  logic [CW-1:0] orow_q, orow_d, ocol_q, ocol_d;

  assign stall       = ov_q & ~out_ready_i;
  assign pipe_empty  = ~v1_q & ~ov_q;
  assign conv_en_o   = v1_q & ~stall;
  assign busy_o      = (state_q != IDLE);
  assign out_valid_o = ov_q;
  assign out_row_o   = orow_q;
  assign out_col_o   = ocol_q;

  conv_scan_cnt #(
    .COLS (IMG_W),
    .ROWS (IMG_H - K + 1),
    .CW   (CW)
  ) u_rd_cnt (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (cnt_clr),
    .en_i   (rd_en_o),
    .row_o  (rd_row_o),
    .col_o  (rd_col_o),
    .last_o (cnt_last)
  );

  // Scan sequencing: issue reads in SCAN, then wait in DRAIN for the pipe to empty.
  always_comb begin
    state_d = state_q;
    rd_en_o = 1'b0;
    cnt_clr = 1'b0;
    done_o  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          cnt_clr = 1'b1;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (!stall) begin
          rd_en_o = 1'b1;
          if (cnt_last) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pipe_empty) begin
          done_o  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Coordinate/valid pipeline: read stage, then window-output stage.
  // Every stage holds during a stall.
  always_comb begin
    v1_d   = v1_q;
    r1_d   = r1_q;
    c1_d   = c1_q;
    ov_d   = ov_q;
    orow_d = orow_q;
    ocol_d = ocol_q;
    if (!stall) begin
      v1_d = rd_en_o;
      r1_d = rd_row_o;
      c1_d = rd_col_o;
      ov_d = conv_en_o && (c1_q >= CW'(K - 1));
      if (ov_d) begin
        orow_d = r1_q;
        ocol_d = c1_q - CW'(K - 1);
      end
    end
  end

  // State and pipeline registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      v1_q    <= 1'b0;
      r1_q    <= '0;
      c1_q    <= '0;
      ov_q    <= 1'b0;
      orow_q  <= '0;
      ocol_q  <= '0;
    end else begin
      state_q <= state_d;
      v1_q    <= v1_d;
      r1_q    <= r1_d;
      c1_q    <= c1_d;
      ov_q    <= ov_d;
      orow_q  <= orow_d;
      ocol_q  <= ocol_d;
    end
  end

endmodule

// File: doc/conv_scan_ctrl.md
CONV_SCAN_CTRL -- requirements
Module: conv_scan_ctrl

Interface
REQ-001 Parameter IMG_W, default 32: input feature-map width in pixels.
REQ-002 Parameter IMG_H, default 32: input feature-map height in pixels.
REQ-003 Parameter K, default 5: convolution window size.
REQ-004 Parameter CW, default 6: coordinate width; SHALL hold max(IMG_W,IMG_H)-1.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 start  in  1  one-cycle request to scan one feature map.
REQ-008 busy  out  1  high from accepted start until the done cycle, inclusive.
REQ-009 done  out  1  one-cycle pulse after the last window has been accepted.
REQ-010 rd_en  out  1  read strobe to the K-bank row buffer.
REQ-011 rd_row  out  CW  top row of the K-row band being read; bank k reads row rd_row+k.
REQ-012 rd_col  out  CW  column being read in all K banks.
REQ-013 conv_en  out  1  shift-enable to the 5x5 window datapath.
REQ-014 out_valid  out  1  window datapath output is a complete window.
REQ-015 out_ready  in  1  downstream accepts the output when high with out_valid.
REQ-016 out_row, out_col  out  CW each  output-pixel coordinates of the valid window.

Function
REQ-017 States SHALL be IDLE, SCAN, DRAIN.
REQ-018 IDLE: start=1 SHALL clear rd_row and rd_col and enter SCAN next cycle; start outside IDLE SHALL be ignored.
REQ-019 SCAN, not stalled: rd_en=1 every cycle.
REQ-019a SCAN, not stalled: rd_col SHALL advance 0..IMG_W-1.
REQ-019b SCAN, not stalled: on rd_col=IMG_W-1, rd_col SHALL wrap to 0 and rd_row SHALL increment.
REQ-020 SCAN: a read at rd_row=IMG_H-K, rd_col=IMG_W-1 SHALL be the last read; the state SHALL then go to DRAIN.
REQ-021 Read latency is 1 cycle. The row buffer SHALL hold its read data while rd_en=0.
REQ-022 conv_en SHALL equal rd_en delayed one cycle, gated by the stall of REQ-025.
REQ-023 out_valid SHALL assert the cycle after a conv_en whose column c >= K-1.
REQ-023a For that window: out_row = band row, out_col = c-(K-1).
REQ-023b Columns c < K-1 of each band SHALL load the window without asserting out_valid; the window refills at each new band.
REQ-024 Ordering: output coordinates SHALL be raster order, row-major, each exactly once.
REQ-024a Output count SHALL be (IMG_H-K+1)*(IMG_W-K+1).
REQ-025 Stall = out_valid & ~out_ready. During a stall:
- rd_en=0 and conv_en=0;
- counters and pipeline-valid flags hold;
- out_valid, out_row and out_col hold.
REQ-026 The stall SHALL release in the cycle after out_ready is sampled high; without stalls, throughput is one column per cycle.
REQ-027 DRAIN SHALL stay until the pipeline is empty and the final out_valid has been accepted.
REQ-027a On leaving DRAIN, done=1 for one cycle, busy=1 in that cycle, then IDLE.
REQ-028 start in the done cycle SHALL be ignored; start in the following IDLE cycle SHALL be accepted.
REQ-029 Unstalled latency: start to the first rd_en is 1 cycle; first rd_en to first out_valid is K+1 cycles.

Reset
REQ-030 rst SHALL force IDLE and zero every output, counter and pipeline flag the next edge, including mid-scan.
REQ-031 After rst, the block SHALL accept start in the first cycle rst is low.

Structure
REQ-032 K, the default IMG_W/IMG_H and the state encoding SHALL live in the shared package lenet_pkg.
REQ-033 The row/column raster counter with wrap and last-flag SHALL be one sub-module, conv_scan_cnt, instantiated once for reads; output coordinates derive from a delayed copy.
REQ-034 Elaboration SHALL fail if IMG_W<K or IMG_H<K.

Verification
REQ-035 IMG_W=8, IMG_H=6, K=5, out_ready=1, start -> 16 rd_en cycles, 8 out_valid.
REQ-035a Same run -> coordinates (0,0)..(0,3),(1,0)..(1,3), then a done pulse.
REQ-036 Same config, out_ready=0 for 3 cycles at the 2nd valid -> coordinates held for 4 cycles and no rd_en/conv_en meanwhile.
REQ-036a Same run -> final sequence identical to REQ-035/035a.
REQ-037 rst at the 10th SCAN cycle -> all outputs 0 next cycle.
REQ-037a Then start -> full 8-output scan from (0,0).
REQ-038 start held high throughout a scan -> exactly one scan until done.
REQ-038a After that done, the held start begins a second scan.
REQ-039 IMG_W=IMG_H=K=5 -> 5 reads, single output (0,0), done.
REQ-040 Default 32x32 with random out_ready -> 784 unique outputs in raster order, and rd_en count = 896.
